// File: rtl/id_ex_stage_pkg.sv
// Shared RISC-V pipeline types: ALU-op encodings, decoded control bundle and bubble constant.
package rv_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
      logic [2:0] funct3;
      logic       inst30;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'(12'd0);

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID-side fields and flush in, EX-side fields, stall and counters out.
interface id_ex_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             flush;
   logic             id_valid;
   logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic [1:0]       id_alu_op;
   logic [2:0]       id_funct3;
   logic             id_inst30;
   logic             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src;

   logic             stall;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic [1:0]       ex_alu_op;
   logic [2:0]       ex_funct3;
   logic             ex_inst30;
   logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   modport master (
      output flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_op, id_funct3, id_inst30, id_reg_write, id_mem_read, id_mem_write,
             id_mem_to_reg, id_branch, id_alu_src,
      input  stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_op, ex_funct3, ex_inst30, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_mem_to_reg, ex_branch, ex_alu_src, stall_cnt, flush_cnt
   );

   modport slave (
      input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_op, id_funct3, id_inst30, id_reg_write, id_mem_read, id_mem_write,
             id_mem_to_reg, id_branch, id_alu_src,
      output stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_op, ex_funct3, ex_inst30, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_mem_to_reg, ex_branch, ex_alu_src, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/id_ex_stage_load_use_hazard_unit.sv
// Load-use RAW detection between the load in EX and the instruction in ID.
import rv_pkg::*;

module load_use_hazard_unit (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       raw_hazard
);

   // rs2 is compared even for I-type: a spurious stall is harmless, a missed one is not.
   assign raw_hazard = ex_valid & ex_mem_read & (ex_rd != REG_X0) & id_valid &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion and event counters.
import rv_pkg::*;

module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             raw_hazard_s, stall_s, capture_s;
   ctrl_t            id_ctrl_s, ex_ctrl_r;
   logic             ex_valid_r;
   logic [XLEN-1:0]  ex_pc_r, ex_rs1_data_r, ex_rs2_data_r, ex_imm_r;
   logic [4:0]       ex_rs1_r, ex_rs2_r, ex_rd_r;
   logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

   load_use_hazard_unit u_hazard (
      .ex_valid    (ex_valid_r),
      .ex_mem_read (ex_ctrl_r.mem_read),
      .ex_rd       (ex_rd_r),
      .id_valid    (bus.id_valid),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .raw_hazard  (raw_hazard_s)
   );

   // Gather the decoded ID control bits into one bundle.
   always_comb begin
      id_ctrl_s            = CTRL_NOP;
      id_ctrl_s.reg_write  = bus.id_reg_write;
      id_ctrl_s.mem_read   = bus.id_mem_read;
      id_ctrl_s.mem_write  = bus.id_mem_write;
      id_ctrl_s.mem_to_reg = bus.id_mem_to_reg;
      id_ctrl_s.branch     = bus.id_branch;
      id_ctrl_s.alu_src    = bus.id_alu_src;
      id_ctrl_s.alu_op     = bus.id_alu_op;
      id_ctrl_s.funct3     = bus.id_funct3;
      id_ctrl_s.inst30     = bus.id_inst30;
   end

   assign stall_s   = raw_hazard_s & ~bus.flush & ~rst;
   assign capture_s = bus.id_valid & ~bus.flush & ~stall_s;

   // Pipeline register and counters; every non-capture cycle loads an all-zero bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_r    <= 1'b0;
         ex_ctrl_r     <= CTRL_NOP;
         ex_pc_r       <= {XLEN{1'b0}};
         ex_rs1_data_r <= {XLEN{1'b0}};
         ex_rs2_data_r <= {XLEN{1'b0}};
         ex_imm_r      <= {XLEN{1'b0}};
         ex_rs1_r      <= REG_X0;
         ex_rs2_r      <= REG_X0;
         ex_rd_r       <= REG_X0;
         stall_cnt_r   <= {CNT_W{1'b0}};
         flush_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         if (capture_s) begin
            ex_valid_r    <= 1'b1;
            ex_ctrl_r     <= id_ctrl_s;
            ex_pc_r       <= bus.id_pc;
            ex_rs1_data_r <= bus.id_rs1_data;
            ex_rs2_data_r <= bus.id_rs2_data;
            ex_imm_r      <= bus.id_imm;
            ex_rs1_r      <= bus.id_rs1;
            ex_rs2_r      <= bus.id_rs2;
            ex_rd_r       <= bus.id_rd;
         end else begin
            ex_valid_r    <= 1'b0;
            ex_ctrl_r     <= CTRL_NOP;
            ex_pc_r       <= {XLEN{1'b0}};
            ex_rs1_data_r <= {XLEN{1'b0}};
            ex_rs2_data_r <= {XLEN{1'b0}};
            ex_imm_r      <= {XLEN{1'b0}};
            ex_rs1_r      <= REG_X0;
            ex_rs2_r      <= REG_X0;
            ex_rd_r       <= REG_X0;
         end
         if (bus.flush) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
         if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign bus.stall         = stall_s;
   assign bus.ex_valid      = ex_valid_r;
   assign bus.ex_pc         = ex_pc_r;
   assign bus.ex_rs1_data   = ex_rs1_data_r;
   assign bus.ex_rs2_data   = ex_rs2_data_r;
   assign bus.ex_imm        = ex_imm_r;
   assign bus.ex_rs1        = ex_rs1_r;
   assign bus.ex_rs2        = ex_rs2_r;
   assign bus.ex_rd         = ex_rd_r;
   assign bus.ex_alu_op     = ex_ctrl_r.alu_op;
   assign bus.ex_funct3     = ex_ctrl_r.funct3;
   assign bus.ex_inst30     = ex_ctrl_r.inst30;
   assign bus.ex_reg_write  = ex_ctrl_r.reg_write;
   assign bus.ex_mem_read   = ex_ctrl_r.mem_read;
   assign bus.ex_mem_write  = ex_ctrl_r.mem_write;
   assign bus.ex_mem_to_reg = ex_ctrl_r.mem_to_reg;
   assign bus.ex_branch     = ex_ctrl_r.branch;
   assign bus.ex_alu_src    = ex_ctrl_r.alu_src;
   assign bus.stall_cnt     = stall_cnt_r;
   assign bus.flush_cnt     = flush_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a behavioural model, plus directed literal checks.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [1:0]  alu_op;
      logic [2:0]  f3;
      logic        i30;
      logic        rw, mr, mw, m2r, br, as;
   } instr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(32), .CNT_W(4)) bus ();
   id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   instr_t     m_ex;
   logic [3:0] m_stall_cnt, m_flush_cnt;
   logic       m_known = 1'b0;
   logic       exp_stall = 1'b0;
   logic       last_stall;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic instr_t dut_ex();
      instr_t e;
      e.valid = bus.ex_valid;   e.pc  = bus.ex_pc;      e.rs1d = bus.ex_rs1_data;
      e.rs2d  = bus.ex_rs2_data; e.imm = bus.ex_imm;    e.rs1  = bus.ex_rs1;
      e.rs2   = bus.ex_rs2;     e.rd  = bus.ex_rd;      e.alu_op = bus.ex_alu_op;
      e.f3    = bus.ex_funct3;  e.i30 = bus.ex_inst30;  e.rw = bus.ex_reg_write;
      e.mr    = bus.ex_mem_read; e.mw = bus.ex_mem_write; e.m2r = bus.ex_mem_to_reg;
      e.br    = bus.ex_branch;  e.as  = bus.ex_alu_src;
      return e;
   endfunction

   function automatic instr_t rand_instr();
      instr_t v;
      v.valid = ($urandom_range(0, 7) != 0);
      v.pc = $urandom; v.rs1d = $urandom; v.rs2d = $urandom; v.imm = $urandom;
      v.rs1 = 5'($urandom_range(0, 7)); v.rs2 = 5'($urandom_range(0, 7));
      v.rd  = 5'($urandom_range(0, 7));
      v.alu_op = 2'($urandom_range(0, 3)); v.f3 = 3'($urandom); v.i30 = 1'($urandom);
      v.rw = 1'($urandom); v.mr = ($urandom_range(0, 2) == 0); v.mw = 1'($urandom);
      v.m2r = 1'($urandom); v.br = 1'($urandom); v.as = 1'($urandom);
      return v;
   endfunction

   function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [1:0] op, input logic i30, input logic mr);
      instr_t v = '0;
      v.valid = 1'b1; v.pc = 32'h0000_0100 + {27'd0, rd}; v.rs1d = 32'h1111_0000; v.rs2d = 32'h2222_0000;
      v.imm = 32'h0000_0004; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.alu_op = op; v.i30 = i30;
      v.rw = 1'b1; v.mr = mr; v.m2r = mr; v.as = mr;
      return v;
   endfunction

   // One clock: drive ID, compare current EX against the model, then advance the model.
   task automatic step(input instr_t v, input logic fl, input logic r);
      logic hz;
      @(negedge clk);
      rst = r; bus.flush = fl; bus.id_valid = v.valid;
      bus.id_pc = v.pc; bus.id_rs1_data = v.rs1d; bus.id_rs2_data = v.rs2d; bus.id_imm = v.imm;
      bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2; bus.id_rd = v.rd;
      bus.id_alu_op = v.alu_op; bus.id_funct3 = v.f3; bus.id_inst30 = v.i30;
      bus.id_reg_write = v.rw; bus.id_mem_read = v.mr; bus.id_mem_write = v.mw;
      bus.id_mem_to_reg = v.m2r; bus.id_branch = v.br; bus.id_alu_src = v.as;
      #1;
      last_stall = bus.stall;
      hz = m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) && v.valid &&
           ((m_ex.rd == v.rs1) || (m_ex.rd == v.rs2));
      exp_stall = hz && !fl && !r;
      if (m_known) begin
         chk("stall", {159'd0, bus.stall}, {159'd0, exp_stall});
         chk("ex_bundle", {4'd0, dut_ex()}, {4'd0, m_ex});
         chk("counters", {152'd0, bus.stall_cnt, bus.flush_cnt}, {152'd0, m_stall_cnt, m_flush_cnt});
      end
      if (r) begin
         m_ex = '0; m_stall_cnt = 4'd0; m_flush_cnt = 4'd0; m_known = 1'b1;
      end else begin
         if (fl) m_flush_cnt = m_flush_cnt + 4'd1;
         if (exp_stall) m_stall_cnt = m_stall_cnt + 4'd1;
         if (fl || exp_stall || !v.valid) m_ex = '0;
         else m_ex = v;
      end
      @(posedge clk);
   endtask

   instr_t lw5, lw0, add_dep, add_x0, add_nodep, sub_i, add_i, junk, v;

   initial begin
      lw5       = mk(5'd5, 5'd2, 5'd0, 2'b00, 1'b0, 1'b1);
      lw0       = mk(5'd0, 5'd2, 5'd0, 2'b00, 1'b0, 1'b1);
      add_dep   = mk(5'd6, 5'd5, 5'd7, 2'b10, 1'b0, 1'b0);
      add_x0    = mk(5'd6, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0);
      add_nodep = mk(5'd10, 5'd8, 5'd9, 2'b10, 1'b0, 1'b0);
      add_i     = mk(5'd5, 5'd6, 5'd7, 2'b10, 1'b0, 1'b0);
      sub_i     = mk(5'd5, 5'd6, 5'd7, 2'b10, 1'b1, 1'b0);
      junk      = '1;
      m_ex = '0; m_stall_cnt = 4'd0; m_flush_cnt = 4'd0;

      // Reset with busy nonzero ID inputs.
      step(junk, 1'b0, 1'b1);
      step(junk, 1'b0, 1'b1);
      #1;
      chk("reset_ex", {4'd0, dut_ex()}, 160'd0);
      chk("reset_cnt", {152'd0, bus.stall_cnt, bus.flush_cnt}, 160'd0);

      // Pass-through add then sub.
      step(add_i, 1'b0, 1'b0);
      #1;
      chk("add_alu_op", {158'd0, bus.ex_alu_op}, 160'd2);
      chk("add_rd", {155'd0, bus.ex_rd}, 160'd5);
      chk("add_flags", {157'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_inst30}, 160'd6);
      chk("add_pc", {128'd0, bus.ex_pc}, 160'h105);
      step(sub_i, 1'b0, 1'b0);
      #1;
      chk("sub_inst30", {159'd0, bus.ex_inst30}, 160'd1);

      // Load-use: one stall, one bubble, then the add proceeds.
      step(lw5, 1'b0, 1'b0);
      step(add_dep, 1'b0, 1'b0);
      chk("lu_stall", {159'd0, last_stall}, 160'd1);
      #1;
      chk("lu_bubble", {4'd0, dut_ex()}, 160'd0);
      chk("lu_stall_cnt", {156'd0, bus.stall_cnt}, 160'd1);
      step(add_dep, 1'b0, 1'b0);
      chk("lu_release", {159'd0, last_stall}, 160'd0);
      #1;
      chk("lu_add_in_ex", {154'd0, bus.ex_valid, bus.ex_rd}, {154'd0, 1'b1, 5'd6});

      // x0 and independent registers never stall.
      step(lw0, 1'b0, 1'b0);
      step(add_x0, 1'b0, 1'b0);
      chk("x0_nostall", {159'd0, last_stall}, 160'd0);
      step(lw5, 1'b0, 1'b0);
      step(add_nodep, 1'b0, 1'b0);
      chk("nodep_nostall", {159'd0, last_stall}, 160'd0);

      // Flush wins over a hazard in the same cycle.
      step(lw5, 1'b0, 1'b0);
      step(add_dep, 1'b1, 1'b0);
      chk("fl_nostall", {159'd0, last_stall}, 160'd0);
      #1;
      chk("fl_bubble", {159'd0, bus.ex_valid}, 160'd0);
      chk("fl_cnts", {152'd0, bus.stall_cnt, bus.flush_cnt}, {152'd0, 4'd1, 4'd1});

      // Counter wrap with a 4-bit stall counter.
      step(junk, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step(lw5, 1'b0, 1'b0);
         step(add_dep, 1'b0, 1'b0);
         step(add_dep, 1'b0, 1'b0);
      end
      #1;
      chk("wrap16", {156'd0, bus.stall_cnt}, 160'd0);
      step(lw5, 1'b0, 1'b0);
      step(add_dep, 1'b0, 1'b0);
      #1;
      chk("wrap17", {156'd0, bus.stall_cnt}, 160'd1);

      // Random traffic; a stalled ID instruction is re-presented as IF/ID would.
      v = rand_instr();
      for (int i = 0; i < 3000; i++) begin
         logic r, fl;
         if (!exp_stall) v = rand_instr();
         r  = ($urandom_range(0, 99) == 0);
         fl = ($urandom_range(0, 7) == 0);
         step(v, fl, r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures decoded control bits (including ALUop, funct3 and instruction bit 30 for the ALU control unit), operands, immediate, register indices and PC, and presents them to EX one cycle later.
- Contains load-use hazard detection: generates the stall for PC and IF/ID, and inserts bubbles on stall, flush or invalid input.
- Keeps stall and flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CNT_W, 32, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch taken, resolved downstream; kill the instruction in ID
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_alu_op  in  2  00 add (ld/st), 01 sub (branch), 10 R-type (decode funct)
- id_funct3  in  3  instruction bits 14:12
- id_inst30  in  1  instruction bit 30
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src  in  1 each  main control bits
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered copies
- ex_alu_op  out  2; ex_funct3  out  3; ex_inst30  out  1  registered copies, feed ALU control
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src  out  1 each  registered copies
- stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Reset:
  - rst=1 at a rising edge clears every registered output and both counters to 0.
  - rst overrides flush, stall and id inputs.
  - Reset mid-instruction discards it; no partial state survives.
- Hazard (combinational):
  - Raw hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - The rs2 compare is always made, even for I-type instructions. This is conservative by design.
  - stall = raw hazard & ~flush & ~rst.
- Register update at each edge, when rst=0, in priority order:
  - (1) flush=1: bubble.
  - (2) stall=1: bubble. IF/ID holds, so the same ID instruction is re-presented next cycle. It is then hazard-free, because EX now holds the bubble.
  - (3) id_valid=0: bubble.
  - (4) Otherwise: capture all id_* fields into ex_*, and ex_valid=1.
- Bubble definition:
  - ex_valid=0.
  - All six control bits = 0.
  - ex_alu_op=00, ex_funct3=000, ex_inst30=0.
  - ex_rd/rs1/rs2=0, data fields=0. A bubble can never write a register or memory.
- Latency: exactly 1 cycle from ID to EX. No throughput loss except load-use (1 bubble) and flush (1 bubble in this stage).
- Counters:
  - stall_cnt increments on each edge where stall=1.
  - flush_cnt increments on each edge where flush=1 (counted even when id_valid=0).
  - Both wrap modulo 2^CNT_W, with no saturation.
  - Flush and raw hazard in the same cycle: flush_cnt+1, stall_cnt unchanged.
- No combinational path from id_* data to any ex_* output. The only combinational output is stall.

Decomposition:
- Shared package rv_pkg:
  - ALUop constants (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10).
  - ctrl_t packed struct holding the six control bits plus alu_op, funct3 and inst30.
  - REG_X0=5'd0.
  - Bubble constant CTRL_NOP, all zeros.
- Sub-module load_use_hazard_unit:
  - Purely combinational.
  - Inputs: ex_valid, ex_mem_read, ex_rd, id_valid, id_rs1, id_rs2.
  - Output: raw hazard.
  - Reused later by the forwarding and hazard work.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 and all id_* nonzero -> all ex_* 0, ex_valid=0, stall=0, counters 0; first edge after release captures ID.
- Pass-through: add x5,x6,x7 (alu_op=10, funct3=000, inst30=0, rd=5, reg_write=1) -> next cycle ex_alu_op=10, ex_inst30=0, ex_rd=5, ex_reg_write=1, ex_valid=1. Repeat with sub (inst30=1) -> ex_inst30=1.
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), add x6,x5,x7 in ID -> stall=1 for one cycle, next EX is a bubble, stall_cnt=1; the following cycle the add appears with ex_valid=1 and stall=0.
- x0 / no-dependency: lw x0 in EX with ID using rs1=0 -> stall=0. lw x5 in EX with ID using x8,x9 -> stall=0.
- Flush+hazard same cycle: hazard conditions met and flush=1 -> stall=0, next EX is a bubble, flush_cnt=1, stall_cnt=0.
- Wrap: CNT_W=4, 16 consecutive load-use stalls -> stall_cnt returns to 0; 17th stall -> stall_cnt=1.
